// File: rtl/seg_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module   : seg_interval_timer
//  Purpose  : Interval timer with loadable compare/wrap points, periodic or
//             one-shot operation, pacing segment/SPI logic. Falling-edge state.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_interval_timer #(
   parameter int WIDTH       = 13,
   parameter int CMP_DEFAULT = 5000,
   parameter int TOP_DEFAULT = 5264
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_cmp,
   input  logic [WIDTH-1:0] load_top,
   output logic             tiempo,
   output logic             wrap,
   output logic             busy,
   output logic             done,
   output logic             load_err,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] c_cmp_rst = WIDTH'(CMP_DEFAULT);
   localparam logic [WIDTH-1:0] c_top_rst = WIDTH'(TOP_DEFAULT);
   localparam logic [WIDTH-1:0] c_zero    = '0;
   localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state,    w_state_nxt;
   logic [WIDTH-1:0] r_count,    w_count_nxt;
   logic [WIDTH-1:0] r_cmp,      w_cmp_nxt;
   logic [WIDTH-1:0] r_top,      w_top_nxt;
   logic             r_mode,     w_mode_nxt;
   logic             r_tiempo,   w_tiempo_nxt;
   logic             r_wrap,     w_wrap_nxt;
   logic             r_load_err, w_load_err_nxt;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_count    <= c_zero;
         r_cmp      <= c_cmp_rst;
         r_top      <= c_top_rst;
         r_mode     <= 1'b0;
         r_tiempo   <= 1'b0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_cmp      <= w_cmp_nxt;
         r_top      <= w_top_nxt;
         r_mode     <= w_mode_nxt;
         r_tiempo   <= w_tiempo_nxt;
         r_wrap     <= w_wrap_nxt;
         r_load_err <= w_load_err_nxt;
      end
   end

   // Priority stop > start > load; pulses default low every edge.
   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_cmp_nxt      = r_cmp;
      w_top_nxt      = r_top;
      w_mode_nxt     = r_mode;
      w_tiempo_nxt   = 1'b0;
      w_wrap_nxt     = 1'b0;
      w_load_err_nxt = 1'b0;

      if (stop) begin
         w_state_nxt = ST_IDLE;
         w_count_nxt = c_zero;
      end else if (start) begin
         // A load alongside start from IDLE/DONE governs the new run.
         if (load && (r_state != ST_RUN)) begin
            w_cmp_nxt = load_cmp;
            w_top_nxt = load_top;
         end
         w_state_nxt = ST_RUN;
         w_count_nxt = c_zero;
         w_mode_nxt  = mode;
      end else begin
         if (load) begin
            if (r_state == ST_RUN) begin
               w_load_err_nxt = 1'b1;
            end else begin
               w_cmp_nxt = load_cmp;
               w_top_nxt = load_top;
            end
         end

         if ((r_state == ST_RUN) && enable) begin
            if (r_count == r_top) begin
               w_count_nxt = c_zero;
               w_wrap_nxt  = 1'b1;
               if (r_mode) begin
                  w_state_nxt = ST_DONE;
               end
            end else begin
               w_count_nxt = r_count + c_one;
            end
            // Independent of the wrap check so cmp == top fires both.
            if (r_count == r_cmp) begin
               w_tiempo_nxt = 1'b1;
            end
         end
      end
   end

   assign tiempo   = r_tiempo;
   assign wrap     = r_wrap;
   assign busy     = (r_state == ST_RUN);
   assign done     = (r_state == ST_DONE);
   assign load_err = r_load_err;
   assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seg_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_interval_timer
//  Purpose  : Directed self-checking bench for seg_interval_timer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_interval_timer;

   localparam int WIDTH = 13;

   logic             clk;
   logic             rst;
   logic             enable;
   logic             start;
   logic             stop;
   logic             mode;
   logic             load;
   logic [WIDTH-1:0] load_cmp;
   logic [WIDTH-1:0] load_top;
   logic             tiempo;
   logic             wrap;
   logic             busy;
   logic             done;
   logic             load_err;
   logic [WIDTH-1:0] count;

   int tests;
   int fails;

   seg_interval_timer #(
      .WIDTH       (WIDTH),
      .CMP_DEFAULT (5000),
      .TOP_DEFAULT (5264)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .load     (load),
      .load_cmp (load_cmp),
      .load_top (load_top),
      .tiempo   (tiempo),
      .wrap     (wrap),
      .busy     (busy),
      .done     (done),
      .load_err (load_err),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active (falling) edge and settle before sampling.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      tests++;
      if ({count, tiempo, wrap, busy, done, load_err} !== {13'd0, 5'b00000}) begin
         fails++;
         $display("FAIL reset_state: count=%0d t=%b w=%b busy=%b done=%b lerr=%b, required all 0",
                  count, tiempo, wrap, busy, done, load_err);
      end
      rst = 1'b0;
      tick();
      tests++;
      if (busy !== 1'b0 || count !== 13'd0) begin
         fails++;
         $display("FAIL reset_idle_hold: busy=%b count=%0d, required 0/0", busy, count);
      end
   endtask

   task automatic test_defaults_periodic();
      int t_n, w_n, t1, t2, w1, w2;
      t_n = 0; w_n = 0; t1 = 0; t2 = 0; w1 = 0; w2 = 0;
      start = 1'b1; mode = 1'b0; enable = 1'b1;
      tick();
      start = 1'b0;
      tests++;
      if (busy !== 1'b1 || count !== 13'd0) begin
         fails++;
         $display("FAIL start_state: busy=%b count=%0d, required 1/0", busy, count);
      end
      for (int k = 1; k <= 10600; k++) begin
         tick();
         if (k == 1) begin
            tests++;
            if (count !== 13'd1) begin
               fails++;
               $display("FAIL first_increment: count=%0d, required 1", count);
            end
         end
         if (tiempo === 1'b1) begin
            t_n++;
            if (t_n == 1) t1 = k;
            if (t_n == 2) t2 = k;
         end
         if (wrap === 1'b1) begin
            w_n++;
            if (w_n == 1) w1 = k;
            if (w_n == 2) w2 = k;
         end
      end
      tests++;
      if (t1 != 5001 || t2 != 10266 || t_n != 2) begin
         fails++;
         $display("FAIL default_tiempo: edges %0d,%0d count %0d, required 5001,10266 count 2", t1, t2, t_n);
      end
      tests++;
      if (w1 != 5265 || w2 != 10530 || w_n != 2) begin
         fails++;
         $display("FAIL default_wrap: edges %0d,%0d count %0d, required 5265,10530 count 2", w1, w2, w_n);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tests++;
      if (busy !== 1'b0 || count !== 13'd0) begin
         fails++;
         $display("FAIL stop_idle: busy=%b count=%0d, required 0/0", busy, count);
      end
   endtask

   task automatic test_load_oneshot();
      logic [WIDTH-1:0] exp_cnt;
      load = 1'b1; load_cmp = 13'd3; load_top = 13'd7;
      tick();
      load = 1'b0;
      tests++;
      if (load_err !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_load: load_err=%b busy=%b, required 0/0", load_err, busy);
      end
      start = 1'b1; mode = 1'b1; enable = 1'b1;
      tick();
      start = 1'b0; mode = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_cnt = (k == 8) ? 13'd0 : WIDTH'(k);
         tests++;
         if (count !== exp_cnt || tiempo !== (k == 4) || wrap !== (k == 8)) begin
            fails++;
            $display("FAIL oneshot_edge%0d: count=%0d t=%b w=%b, required count=%0d t=%b w=%b",
                     k, count, tiempo, wrap, exp_cnt, (k == 4), (k == 8));
         end
      end
      tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL oneshot_done: done=%b busy=%b, required 1/0", done, busy);
      end
      tick();
      tick();
      tests++;
      if (count !== 13'd0 || done !== 1'b1 || tiempo !== 1'b0 || wrap !== 1'b0) begin
         fails++;
         $display("FAIL done_hold: count=%0d done=%b t=%b w=%b, required 0/1/0/0", count, done, tiempo, wrap);
      end
   endtask

   task automatic test_enable_gating();
      logic             en_v  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [WIDTH-1:0] cnt_v [5] = '{13'd1, 13'd1, 13'd1, 13'd2, 13'd3};
      logic             tie_v [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      load = 1'b1; load_cmp = 13'd2; load_top = 13'd5;
      tick();
      load = 1'b0;
      tests++;
      if (load_err !== 1'b0 || done !== 1'b1) begin
         fails++;
         $display("FAIL done_load: load_err=%b done=%b, required 0/1", load_err, done);
      end
      start = 1'b1; mode = 1'b0; enable = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         enable = en_v[i];
         tick();
         tests++;
         if (count !== cnt_v[i] || tiempo !== tie_v[i]) begin
            fails++;
            $display("FAIL gate_step%0d: count=%0d t=%b, required count=%0d t=%b",
                     i, count, tiempo, cnt_v[i], tie_v[i]);
         end
      end
      enable = 1'b0;
      tick();
      tests++;
      if (count !== 13'd3 || tiempo !== 1'b0) begin
         fails++;
         $display("FAIL gate_once: count=%0d t=%b, required 3/0", count, tiempo);
      end
   endtask

   task automatic test_load_in_run();
      enable = 1'b1;
      load = 1'b1; load_cmp = 13'd1; load_top = 13'd2;
      tick();
      load = 1'b0;
      tests++;
      if (load_err !== 1'b1 || count !== 13'd4) begin
         fails++;
         $display("FAIL run_load_err: load_err=%b count=%0d, required 1/4", load_err, count);
      end
      tick();
      tests++;
      if (load_err !== 1'b0 || count !== 13'd5 || wrap !== 1'b0) begin
         fails++;
         $display("FAIL run_load_pulse: load_err=%b count=%0d w=%b, required 0/5/0", load_err, count, wrap);
      end
      tick();
      tests++;
      if (wrap !== 1'b1 || count !== 13'd0) begin
         fails++;
         $display("FAIL limits_kept_top: w=%b count=%0d, required 1/0", wrap, count);
      end
      tick();
      tick();
      tick();
      tests++;
      if (tiempo !== 1'b1 || count !== 13'd3) begin
         fails++;
         $display("FAIL limits_kept_cmp: t=%b count=%0d, required 1/3", tiempo, count);
      end
      tick();
      tick();
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || count !== 13'd0 || wrap !== 1'b0 || tiempo !== 1'b0) begin
         fails++;
         $display("FAIL stop_start: busy=%b done=%b count=%0d w=%b t=%b, required 0/0/0/0/0",
                  busy, done, count, wrap, tiempo);
      end
   endtask

   task automatic test_cmp_eq_top();
      logic [WIDTH-1:0] exp_cnt;
      logic             exp_p;
      load = 1'b1; load_cmp = 13'd4; load_top = 13'd4;
      tick();
      load = 1'b0;
      start = 1'b1; mode = 1'b0; enable = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         exp_cnt = WIDTH'(k % 5);
         exp_p   = ((k % 5) == 0);
         tests++;
         if (count !== exp_cnt || tiempo !== exp_p || wrap !== exp_p) begin
            fails++;
            $display("FAIL eq_edge%0d: count=%0d t=%b w=%b, required count=%0d t=w=%b",
                     k, count, tiempo, wrap, exp_cnt, exp_p);
         end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_async_reset();
      int t_first, w_n;
      t_first = 0; w_n = 0;
      load = 1'b1; load_cmp = 13'd200; load_top = 13'd300;
      tick();
      load = 1'b0;
      start = 1'b1; mode = 1'b0; enable = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 99; k++) tick();
      load = 1'b1; load_cmp = 13'd7; load_top = 13'd9;
      tick();
      load = 1'b0;
      tests++;
      if (count !== 13'd100 || load_err !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset: count=%0d load_err=%b, required 100/1", count, load_err);
      end
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if ({count, tiempo, wrap, busy, done, load_err} !== {13'd0, 5'b00000}) begin
         fails++;
         $display("FAIL async_reset: count=%0d t=%b w=%b busy=%b done=%b lerr=%b, required all 0",
                  count, tiempo, wrap, busy, done, load_err);
      end
      #1;
      rst = 1'b0;
      start = 1'b1; mode = 1'b0; enable = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 5001; k++) begin
         tick();
         if (tiempo === 1'b1 && t_first == 0) t_first = k;
         if (wrap === 1'b1) w_n++;
      end
      tests++;
      if (t_first != 5001 || w_n != 0) begin
         fails++;
         $display("FAIL reset_limits: first tiempo edge %0d wraps %0d, required 5001 and 0", t_first, w_n);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
      load = 1'b0; load_cmp = '0; load_top = '0;
      test_reset();
      test_defaults_periodic();
      test_load_oneshot();
      test_enable_gating();
      test_load_in_run();
      test_cmp_eq_top();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      tests++;
      fails++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_interval_timer.md
# seg_interval_timer

Parametrised interval timer for the SPI timing path: a WIDTH-bit counter with a run-time loadable compare point and wrap point. Supports periodic and one-shot modes, start/stop control and enable gating. It produces a one-cycle `tiempo` pulse at the compare count and a one-cycle `wrap` pulse at the wrap count. It drives segment/SPI pacing logic, and its defaults give a 5000-count compare inside a 5265-count period.

## Interface
- `WIDTH`, 13: counter and limit width in bits.
- `CMP_DEFAULT`, 5000: compare value after reset.
- `TOP_DEFAULT`, 5264: wrap value after reset; period is TOP+1 enabled cycles.
- `clk`  in  1  clock. All state updates on the falling edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  count enable. Counter holds while low.
- `start`  in  1  start or restart request, sampled per edge.
- `stop`  in  1  stop request, sampled per edge.
- `mode`  in  1  0 = periodic, 1 = one-shot. Sampled when start is accepted.
- `load`  in  1  load `load_cmp`/`load_top` into the limit registers.
- `load_cmp`  in  WIDTH  new compare value.
- `load_top`  in  WIDTH  new wrap value.
- `tiempo`  out  1  registered one-cycle compare pulse.
- `wrap`  out  1  registered one-cycle wrap pulse.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `load_err`  out  1  one-cycle pulse when `load` is rejected.
- `count`  out  WIDTH  current counter value.

## Operation
- State machine: IDLE, RUN, DONE. A mode register latches `mode` on start.
- Reset (async, immediate):
  - state = IDLE; count = 0; cmp_r = CMP_DEFAULT; top_r = TOP_DEFAULT; mode_r = 0.
  - tiempo, wrap, busy, done and load_err all = 0.
- Control priority per edge: stop > start > load.
- stop:
  - From any state: go to IDLE, count = 0. No tiempo or wrap pulse is generated on that edge.
  - stop and start together: stop wins.
- start:
  - From IDLE or DONE: go to RUN, count = 0, mode_r = mode.
  - In RUN: restart, count = 0, mode_r re-latched, no pulses on that edge.
- RUN with enable = 1 and no stop/start:
  - If count == top_r: count = 0 and wrap = 1 next cycle. If mode_r = 1, go to DONE.
  - Otherwise count = count + 1, modulo 2^WIDTH. This wrap-around is reachable only if top_r cannot be hit, which cannot happen because counting starts at 0 and top_r is fixed during RUN.
  - If count == cmp_r: tiempo = 1 next cycle. This is independent of the wrap check, so cmp_r == top_r gives both pulses on the same edge.
- RUN with enable = 0: count holds; tiempo and wrap are 0.
- cmp_r > top_r: tiempo never fires.
- top_r = 0: wrap fires on every enabled edge.
- load:
  - Accepted only in IDLE or DONE: cmp_r = load_cmp, top_r = load_top.
  - In RUN (and not overridden by stop or start on that edge): ignored, load_err = 1 for one cycle, limits unchanged.
  - load with start from IDLE: load is applied, and the new limits govern the run that starts on that edge.
- DONE: count holds 0, done = 1 until start or stop.
- tiempo, wrap and load_err are deasserted every edge unless re-asserted.

## Timing
- Start accepted at falling edge N: busy = 1 and count = 0 after N. The first increment happens at edge N+1 if enable = 1.
- Periodic mode, enable held high: wrap pulses every top_r+1 edges. tiempo pulses cmp_r+1 edges after the start edge, then every top_r+1 edges.
- Pulse latency: the pulse is registered one edge after the edge on which the condition is sampled. Each pulse lasts exactly one clock period, falling edge to falling edge.
- One-shot mode: done = 1 after the same edge that issues wrap.
- Mid-operation reset: all outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Defaults, periodic:
  - Stimulus: reset, start with mode = 0, enable held high.
  - Required: tiempo after 5001 edges, wrap after 5265 edges, then both repeat every 5265 edges.
- Load and one-shot:
  - Stimulus: load cmp = 3, top = 7 in IDLE, then start with mode = 1.
  - Required: count 0..7; tiempo once at the 4th edge; wrap at the 8th; done = 1; count stays 0.
- Enable gating:
  - Stimulus: cmp = 2, top = 5; toggle enable 1,0,0,1,1.
  - Required: count follows 1,1,1,2,3; tiempo appears one edge after count == 2 while enabled, and only once.
- Load in RUN, then stop/start conflict:
  - Stimulus: assert load while running.
  - Required: load_err pulse and limits unchanged.
  - Stimulus: assert start and stop together.
  - Required: IDLE, count = 0, no pulses.
- cmp == top == 4, periodic:
  - Required: tiempo and wrap pulse on the same edge every 5 edges.
- Async reset mid-run at count = 100:
  - Required: all outputs 0 and count = 0 before the next clock edge; limits back to 5000/5264.
